// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between drawing stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_wind_meter.sv
// Wind indicator overlay: bordered box with a signed fill bar that eases toward
// the captured wind value once per frame. Two-stage pipeline, all fields aligned.
module draw_wind_meter #(
  parameter int          RECT_X         = 342,
  parameter int          RECT_Y         = 40,
  parameter int          RECT_W         = 116,
  parameter int          RECT_H         = 16,
  parameter int          BORDER_W       = 3,
  parameter logic [11:0] BG_COLOR       = 12'hEFF,
  parameter logic [11:0] BORDER_COLOR   = 12'hBDF,
  parameter logic [11:0] FILL_POS_COLOR = 12'h4C4,
  parameter logic [11:0] FILL_NEG_COLOR = 12'hC44,
  parameter logic [11:0] MARK_COLOR     = 12'h000,
  parameter int          WIND_W         = 6,
  parameter int          PIX_PER_UNIT   = 4,
  parameter int          STEP           = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [WIND_W-1:0] wind,
  input  logic                     wind_valid,
  vga_if.vga_in                    vga_in,
  vga_if.vga_out                   vga_out
);

  localparam int          HALF   = RECT_W / 2;
  localparam logic [10:0] IN_X0  = 11'(RECT_X);
  localparam logic [10:0] IN_X1  = 11'(RECT_X + RECT_W);
  localparam logic [10:0] IN_Y0  = 11'(RECT_Y);
  localparam logic [10:0] IN_Y1  = 11'(RECT_Y + RECT_H);
  localparam logic [10:0] BOX_X0 = 11'(RECT_X - BORDER_W);
  localparam logic [10:0] BOX_X1 = 11'(RECT_X + RECT_W + BORDER_W);
  localparam logic [10:0] BOX_Y0 = 11'(RECT_Y - BORDER_W);
  localparam logic [10:0] BOX_Y1 = 11'(RECT_Y + RECT_H + BORDER_W);
  localparam logic [10:0] CX     = 11'(RECT_X + HALF);
  localparam logic [10:0] HALF_L = 11'(HALF);
  localparam logic [10:0] STEP_L = 11'(STEP);
  localparam logic [10:0] PPU_L  = 11'(PIX_PER_UNIT);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  logic signed [WIND_W-1:0] wind_q;
  logic                     vblnk_prev_q;
  logic [10:0]              disp_len_q, disp_len_d;
  logic                     disp_neg_q, disp_neg_d;

  vga_t s1_q, s1_d, out_q, out_d;
  logic inner_q, box_q, mark_q, fill_q, fill_neg_q;
  logic inner_d, box_d, mark_d, fill_d;

  logic              tick;
  logic [WIND_W:0]   wind_ext, mag;
  logic [10:0]       prod, tgt_len;
  logic              tgt_neg;

  assign tick = vga_in.vblnk & ~vblnk_prev_q;

  // One extra bit so the most negative input still has a representable magnitude.
  assign wind_ext = {wind_q[WIND_W-1], wind_q};
  assign mag      = wind_q[WIND_W-1] ? -wind_ext : wind_ext;
  assign prod     = 11'(mag) * PPU_L;
  assign tgt_len  = (prod > HALF_L) ? HALF_L : prod;
  assign tgt_neg  = wind_q[WIND_W-1];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    disp_len_d = disp_len_q;
    disp_neg_d = disp_neg_q;
    if (tick) begin
      if (disp_neg_q == tgt_neg || disp_len_q == '0) begin
        disp_neg_d = tgt_neg;
        if (disp_len_q < tgt_len)
          disp_len_d = (tgt_len - disp_len_q > STEP_L) ? disp_len_q + STEP_L : tgt_len;
        else
          disp_len_d = (disp_len_q - tgt_len > STEP_L) ? disp_len_q - STEP_L : tgt_len;
      end else begin
        disp_len_d = (disp_len_q > STEP_L) ? disp_len_q - STEP_L : '0;
      end
    end
  end

  // Stage 1: region flags from the incoming coordinates and the registered bar length.
  always_comb begin
    s1_d.hcount = vga_in.hcount;
    s1_d.vcount = vga_in.vcount;
    s1_d.hsync  = vga_in.hsync;
    s1_d.vsync  = vga_in.vsync;
    s1_d.hblnk  = vga_in.hblnk;
    s1_d.vblnk  = vga_in.vblnk;
    s1_d.rgb    = vga_in.rgb;
    inner_d = (vga_in.hcount >= IN_X0) && (vga_in.hcount < IN_X1) &&
              (vga_in.vcount >= IN_Y0) && (vga_in.vcount < IN_Y1);
    box_d   = (vga_in.hcount >= BOX_X0) && (vga_in.hcount < BOX_X1) &&
              (vga_in.vcount >= BOX_Y0) && (vga_in.vcount < BOX_Y1);
    mark_d  = inner_d && (vga_in.hcount == CX);
    if (disp_neg_q)
      fill_d = inner_d && (vga_in.hcount >= CX - disp_len_q) && (vga_in.hcount < CX);
    else
      fill_d = inner_d && (vga_in.hcount >= CX) && (vga_in.hcount < CX + disp_len_q);
  end

  // Stage 2: colour priority on registered flags only.
  always_comb begin
    out_d = s1_q;
    if (s1_q.hblnk || s1_q.vblnk) out_d.rgb = 12'h000;
    else if (box_q && !inner_q)   out_d.rgb = BORDER_COLOR;
    else if (mark_q)              out_d.rgb = MARK_COLOR;
    else if (fill_q)              out_d.rgb = fill_neg_q ? FILL_NEG_COLOR : FILL_POS_COLOR;
    else if (inner_q)             out_d.rgb = BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wind_q       <= '0;
      vblnk_prev_q <= 1'b0;
      disp_len_q   <= '0;
      disp_neg_q   <= 1'b0;
      s1_q         <= '0;
      out_q        <= '0;
      inner_q      <= 1'b0;
      box_q        <= 1'b0;
      mark_q       <= 1'b0;
      fill_q       <= 1'b0;
      fill_neg_q   <= 1'b0;
    end else begin
      if (wind_valid) wind_q <= wind;
      vblnk_prev_q <= vga_in.vblnk;
      disp_len_q   <= disp_len_d;
      disp_neg_q   <= disp_neg_d;
      s1_q         <= s1_d;
      out_q        <= out_d;
      inner_q      <= inner_d;
      box_q        <= box_d;
      mark_q       <= mark_d;
      fill_q       <= fill_d;
      fill_neg_q   <= disp_neg_q;
    end
  end

  assign vga_out.hcount = out_q.hcount;
  assign vga_out.vcount = out_q.vcount;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_wind_meter.sv
// Directed bench for draw_wind_meter: pipeline latency, reset, bar animation and
// colour priority, probed pixel by pixel with a compact synthetic timing source.
module tb_draw_wind_meter;

  localparam logic [11:0] BG   = 12'hEFF;
  localparam logic [11:0] BRD  = 12'hBDF;
  localparam logic [11:0] POS  = 12'h4C4;
  localparam logic [11:0] NEG  = 12'hC44;
  localparam int          CX   = 400;
  localparam int          PY   = 45;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [5:0] wind;
  logic              wind_valid;
  logic [11:0]       pix_rgb;
  int                n_checks = 0;
  int                n_errors = 0;

  vga_if vin ();
  vga_if vout ();

  draw_wind_meter dut (
    .clk        (clk),
    .rst        (rst),
    .wind       (wind),
    .wind_valid (wind_valid),
    .vga_in     (vin),
    .vga_out    (vout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_in();
    return 64'({vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb});
  endfunction

  function automatic logic [63:0] pack_out();
    return 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb});
  endfunction

  // Streams pixels outside the box; each output must equal the input from two cycles before.
  task automatic stream(input int n, input int h0);
    logic [63:0] hist [16];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i >= 2) check("latency", pack_out(), hist[i-2]);
      vin.hcount = 11'(h0 + i);
      vin.vcount = 11'(200 + i);
      vin.hsync  = i[0];
      vin.vsync  = i[1];
      vin.hblnk  = 1'b0;
      vin.vblnk  = 1'b0;
      vin.rgb    = 12'(i * 37 + 5);
      hist[i]    = pack_in();
    end
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic hb,
                       input logic [11:0] exp);
    @(negedge clk);
    vin.hcount = 11'(x);
    vin.vcount = 11'(y);
    vin.hblnk  = hb;
    vin.vblnk  = 1'b0;
    vin.rgb    = pix_rgb;
    repeat (2) @(negedge clk);
    check(tag, 64'(vout.rgb), 64'(exp));
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vin.hblnk = 1'b0;
      vin.vblnk = 1'b1;
      @(negedge clk);
      vin.vblnk = 1'b0;
    end
  endtask

  task automatic load_wind(input logic signed [5:0] w);
    @(negedge clk);
    wind       = w;
    wind_valid = 1'b1;
    @(negedge clk);
    wind_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Checks the bar ends for an expected length and side (length below 58).
  task automatic check_len(input string tag, input int len, input logic neg);
    if (len == 0) begin
      probe({tag, "_r"}, CX + 1, PY, 1'b0, BG);
      probe({tag, "_l"}, CX - 1, PY, 1'b0, BG);
    end else if (!neg) begin
      probe({tag, "_end"},  CX + len - 1, PY, 1'b0, POS);
      probe({tag, "_past"}, CX + len,     PY, 1'b0, BG);
      probe({tag, "_oppo"}, CX - 1,       PY, 1'b0, BG);
    end else begin
      probe({tag, "_end"},  CX - len,     PY, 1'b0, NEG);
      probe({tag, "_past"}, CX - len - 1, PY, 1'b0, BG);
      probe({tag, "_oppo"}, CX + 1,       PY, 1'b0, BG);
    end
  endtask

  initial begin
    int   rev_len [10] = '{10, 8, 6, 4, 2, 0, 2, 4, 6, 8};
    logic rev_neg [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

    rst = 1'b1;
    wind = '0;
    wind_valid = 1'b0;
    pix_rgb = 12'h5A5;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
    repeat (3) @(negedge clk);
    check("rst_init", pack_out(), 64'd0);
    rst = 1'b0;
    stream(10, 20);

    // Static ramp toward +5 (20 px).
    load_wind(6'sd5);
    check_len("idle", 0, 1'b0);
    tick(1);  check_len("ramp1", 2, 1'b0);
    tick(4);  check_len("ramp5", 10, 1'b0);
    tick(5);  check_len("ramp10", 20, 1'b0);
    tick(2);  check_len("ramp12", 20, 1'b0);

    // Mid-line reset clears outputs and the bar.
    @(negedge clk);
    vin.hcount = 11'd30; vin.vcount = 11'd100; vin.rgb = 12'h777; vin.hsync = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_out", pack_out(), 64'd0);
    end
    rst = 1'b0;
    stream(8, 60);
    check_len("rst_len", 0, 1'b0);

    // Saturation at the most negative wind.
    load_wind(6'b100000);
    tick(28); check_len("sat28", 56, 1'b1);
    tick(1);
    probe("sat_left",  342, PY, 1'b0, NEG);
    probe("sat_mid",   371, PY, 1'b0, NEG);
    probe("sat_edge",  399, PY, 1'b0, NEG);
    probe("sat_mark",  400, PY, 1'b0, 12'h000);
    probe("sat_right", 401, PY, 1'b0, BG);
    tick(1);
    probe("sat_hold",  342, PY, 1'b0, NEG);
    probe("sat_brd",   341, PY, 1'b0, BRD);

    // Reversal: shrink through zero before crossing the centre.
    do_reset();
    load_wind(6'sd3);
    tick(7);  check_len("rev_start", 12, 1'b0);
    load_wind(-6'sd2);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_len($sformatf("rev%0d", i), rev_len[i], rev_neg[i]);
    end

    // Wind update on the same edge as the tick applies from the next tick.
    do_reset();
    load_wind(6'sd3);
    tick(7);  check_len("same_pre", 12, 1'b0);
    @(negedge clk);
    vin.vblnk = 1'b1; wind = 6'sd7; wind_valid = 1'b1;
    @(negedge clk);
    vin.vblnk = 1'b0; wind_valid = 1'b0;
    check_len("same_edge", 12, 1'b0);
    tick(1);  check_len("same_next", 14, 1'b0);
    tick(1);  check_len("same_next2", 16, 1'b0);

    // Colour priority and blanking.
    probe("prio_border", 340, 38, 1'b0, BRD);
    probe("prio_brd_br", 460, 58, 1'b0, BRD);
    probe("prio_inner",  342, 40, 1'b0, BG);
    probe("prio_in_br",  457, 55, 1'b0, BG);
    probe("prio_blank",  401, PY, 1'b1, 12'h000);
    probe("prio_blank2", 340, 38, 1'b1, 12'h000);
    pix_rgb = 12'hABC;
    probe("prio_pass",   10, 10, 1'b0, 12'hABC);
    probe("prio_out",    461, 59, 1'b0, 12'hABC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
